// File: rtl/cb_point_fetch.sv
// Command-buffer read sequencer: walks a byte range of the command-buffer RAM
// (port B, read-only), pairs consecutive bytes into (x,y) vertices and streams
// them out over a valid/ready handshake, tagging the first and last vertex.
module cb_point_fetch #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] count,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_q,
   output logic              pt_valid,
   input  logic              pt_ready,
   output logic [DATA_W-1:0] pt_x,
   output logic [DATA_W-1:0] pt_y,
   output logic              pt_first,
   output logic              pt_last
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH_X,
      S_FETCH_Y,
      S_CAP_Y,
      S_OUT,
      S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   ptr_q, ptr_d;
   logic [ADDR_W-1:0]   remaining_q, remaining_d;
   logic                first_flag_q, first_flag_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                pt_valid_q, pt_valid_d;
   logic                pt_first_q, pt_first_d;
   logic                pt_last_q, pt_last_d;
   logic [DATA_W-1:0]   pt_x_q, pt_x_d;
   logic [DATA_W-1:0]   pt_y_q, pt_y_d;
   logic                handshake;

   assign handshake = pt_valid_q && pt_ready;

   // Next-state and next-output computation for the fetch sequencer.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves it
      // unassigned; that is what keeps this block from inferring latches.
      state_d      = state_q;
      ptr_d        = ptr_q;
      remaining_d  = remaining_q;
      first_flag_d = first_flag_q;
      pt_valid_d   = pt_valid_q;
      pt_first_d   = pt_first_q;
      pt_last_d    = pt_last_q;
      pt_x_d       = pt_x_q;
      pt_y_d       = pt_y_q;
      done_d       = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               ptr_d        = base_addr;
               remaining_d  = count;
               first_flag_d = 1'b1;
               state_d      = (count == '0) ? S_DONE : S_FETCH_X;
            end
         end
         S_FETCH_X: begin
            // x byte address is on the bus; step to the y byte.
            ptr_d   = ptr_q + ADDR_W'(1);
            state_d = S_FETCH_Y;
         end
         S_FETCH_Y: begin
            pt_x_d  = mem_q;
            state_d = S_CAP_Y;
         end
         S_CAP_Y: begin
            pt_y_d     = mem_q;
            ptr_d      = ptr_q + ADDR_W'(1);
            pt_valid_d = 1'b1;
            pt_first_d = first_flag_q;
            pt_last_d  = (remaining_q == ADDR_W'(1));
            state_d    = S_OUT;
         end
         S_OUT: begin
            // Output register holds until the consumer takes it; no reads meanwhile.
            if (handshake) begin
               pt_valid_d   = 1'b0;
               pt_first_d   = 1'b0;
               pt_last_d    = 1'b0;
               first_flag_d = 1'b0;
               remaining_d  = remaining_q - ADDR_W'(1);
               if (remaining_q == ADDR_W'(1)) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_FETCH_X;
               end
            end
         end
         S_DONE: begin
            // A full run raised done on entry; an empty run raises it on exit.
            done_d  = !done_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign busy_d = (state_d != S_IDLE);

   // State and registered outputs, synchronous active-high reset.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         state_q      <= S_IDLE;
         ptr_q        <= '0;
         remaining_q  <= '0;
         first_flag_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         pt_valid_q   <= 1'b0;
         pt_first_q   <= 1'b0;
         pt_last_q    <= 1'b0;
         pt_x_q       <= '0;
         pt_y_q       <= '0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         remaining_q  <= remaining_d;
         first_flag_q <= first_flag_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         pt_valid_q   <= pt_valid_d;
         pt_first_q   <= pt_first_d;
         pt_last_q    <= pt_last_d;
         pt_x_q       <= pt_x_d;
         pt_y_q       <= pt_y_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign mem_addr = ptr_q;
   assign pt_valid = pt_valid_q;
   assign pt_first = pt_first_q;
   assign pt_last  = pt_last_q;
   assign pt_x     = pt_x_q;
   assign pt_y     = pt_y_q;

endmodule

// File: tb/tb_cb_point_fetch.sv
// Testbench for cb_point_fetch: RAM model, scoreboard queue of expected vertices,
// independent monitor, directed cycle checks and randomized runs.
module tb_cb_point_fetch;

   localparam int ADDR_W = 10;
   localparam int DATA_W = 8;
   localparam int DEPTH  = 1 << ADDR_W;

   typedef struct {
      int x;
      int y;
      int first;
      int last;
   } vtx_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] base_addr = '0;
   logic [ADDR_W-1:0] count = '0;
   logic              busy;
   logic              done;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_q = '0;
   logic              pt_valid;
   logic              pt_ready = 1'b1;
   logic [DATA_W-1:0] pt_x;
   logic [DATA_W-1:0] pt_y;
   logic              pt_first;
   logic              pt_last;

   logic [DATA_W-1:0] ram [0:DEPTH-1];
   vtx_t              exp_q [$];
   int                checks = 0;
   int                failures = 0;
   int                done_cnt = 0;
   bit                rnd_ready = 0;

   int tv [0:15];
   int td [0:15];
   int tb_ [0:15];
   int ta [0:15];
   int tx [0:15];
   int ty [0:15];
   int tf [0:15];
   int tl [0:15];

   cb_point_fetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
      .busy(busy), .done(done), .mem_addr(mem_addr), .mem_q(mem_q),
      .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_x(pt_x), .pt_y(pt_y),
      .pt_first(pt_first), .pt_last(pt_last)
   );

   always #5 clk = ~clk;

   // Port-B read: data valid one cycle after the address.
   always @(posedge clk) mem_q <= ram[mem_addr];

   // Random back-pressure during the randomized phase.
   always @(posedge clk) begin
      #1;
      if (rnd_ready) pt_ready = ($urandom_range(0, 3) != 0);
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: pops the scoreboard on every handshake, checks stalls and done.
   bit stall_prev = 0;
   int sx, sy, sf, sl, sa;
   always @(negedge clk) begin
      if (rst) begin
         stall_prev = 0;
      end else begin
         if (stall_prev) begin
            check("stall_valid", int'(pt_valid), 1);
            check("stall_x", int'(pt_x), sx);
            check("stall_y", int'(pt_y), sy);
            check("stall_flags", {pt_first, pt_last}, {sf[0], sl[0]});
            check("stall_addr", int'(mem_addr), sa);
         end
         if (pt_valid && pt_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_vertex", 1, 0);
            end else begin
               vtx_t e;
               e = exp_q.pop_front();
               check("pt_x", int'(pt_x), e.x);
               check("pt_y", int'(pt_y), e.y);
               check("pt_first", int'(pt_first), e.first);
               check("pt_last", int'(pt_last), e.last);
            end
         end
         if (done) begin
            done_cnt++;
            check("done_queue_empty", exp_q.size(), 0);
         end
         stall_prev = pt_valid && !pt_ready;
         sx = int'(pt_x); sy = int'(pt_y); sf = int'(pt_first); sl = int'(pt_last);
         sa = int'(mem_addr);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue a run and push the vertices the buffer contents imply.
   task automatic start_run(input int b, input int c);
      start = 1'b1;
      base_addr = ADDR_W'(b);
      count = ADDR_W'(c);
      for (int i = 0; i < c; i++) begin
         vtx_t v;
         v.x = int'(ram[(b + 2 * i) % DEPTH]);
         v.y = int'(ram[(b + 2 * i + 1) % DEPTH]);
         v.first = (i == 0) ? 1 : 0;
         v.last = (i == c - 1) ? 1 : 0;
         exp_q.push_back(v);
      end
      step();
      start = 1'b0;
   endtask

   // Record outputs for cycles 1..n after the start cycle.
   task automatic trace(input int n);
      for (int k = 1; k <= n; k++) begin
         @(negedge clk);
         tv[k] = int'(pt_valid); td[k] = int'(done); tb_[k] = int'(busy);
         ta[k] = int'(mem_addr); tx[k] = int'(pt_x); ty[k] = int'(pt_y);
         tf[k] = int'(pt_first); tl[k] = int'(pt_last);
      end
      #1;
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (!done && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (!done) check("done_timeout", 0, 1);
      step();
   endtask

   initial begin
      int d0;
      int seen;
      for (int i = 0; i < DEPTH; i++) ram[i] = DATA_W'($urandom);

      // Reset state
      repeat (3) step();
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_valid", int'(pt_valid), 0);
      check("rst_addr", int'(mem_addr), 0);
      check("rst_xy", {pt_x, pt_y}, 0);
      rst = 1'b0;
      step();

      // Basic two-vertex run
      ram[0] = 8'd26; ram[1] = 8'd25; ram[2] = 8'd41; ram[3] = 8'd26;
      start_run(0, 2);
      trace(10);
      check("t1_busy_c1", tb_[1], 1);
      check("t1_valid_c3", tv[3], 0);
      check("t1_valid_c4", tv[4], 1);
      check("t1_xy_c4", tx[4] * 256 + ty[4], 26 * 256 + 25);
      check("t1_first_c4", tf[4], 1);
      check("t1_valid_c8", tv[8], 1);
      check("t1_xy_c8", tx[8] * 256 + ty[8], 41 * 256 + 26);
      check("t1_last_c8", tl[8], 1);
      check("t1_done_c8", td[8], 0);
      check("t1_done_c9", td[9], 1);
      check("t1_busy_c9", tb_[9], 1);
      check("t1_done_c10", td[10], 0);
      check("t1_busy_c10", tb_[10], 0);

      // Single vertex
      start_run(100, 1);
      trace(6);
      check("t2_first_last", tf[4] * 2 + tl[4], 3);
      check("t2_done_c5", td[5], 1);

      // Empty run
      d0 = done_cnt;
      start_run(5, 0);
      trace(6);
      check("t3_busy_c1", tb_[1], 1);
      check("t3_busy_c2", tb_[2], 0);
      check("t3_done_c1", td[1], 0);
      check("t3_done_c2", td[2], 1);
      seen = 0;
      for (int k = 1; k <= 6; k++) seen += tv[k];
      check("t3_no_valid", seen, 0);
      check("t3_done_once", done_cnt - d0, 1);

      // Wrap-around run
      ram[1023] = 8'd7; ram[0] = 8'd9; ram[1] = 8'd11; ram[2] = 8'd13;
      start_run(1023, 2);
      trace(10);
      check("t4_addr_c1", ta[1], 1023);
      check("t4_addr_c2", ta[2], 0);
      check("t4_addr_c5", ta[5], 1);
      check("t4_addr_c6", ta[6], 2);
      check("t4_xy_v1", tx[4] * 256 + ty[4], 7 * 256 + 9);
      check("t4_xy_v2", tx[8] * 256 + ty[8], 11 * 256 + 13);

      // Back-pressure with ignored start pulses
      d0 = done_cnt;
      pt_ready = 1'b0;
      start_run(10, 2);
      repeat (3) step();
      check("t5_valid_c4", int'(pt_valid), 1);
      for (int i = 0; i < 5; i++) begin
         start = (i == 1 || i == 2);
         base_addr = 10'd500;
         count = 10'd3;
         step();
      end
      start = 1'b0;
      pt_ready = 1'b1;
      wait_done(60);
      check("t5_done_once", done_cnt - d0, 1);
      seen = 0;
      for (int k = 0; k < 8; k++) begin
         step();
         seen += int'(pt_valid) + int'(busy);
      end
      check("t5_no_requeue", seen, 0);

      // Reset in FETCH_Y of vertex 2
      d0 = done_cnt;
      start_run(0, 2);
      repeat (5) step();
      rst = 1'b1;
      step();
      check("t6_busy", int'(busy), 0);
      check("t6_valid", int'(pt_valid), 0);
      check("t6_outs", {done, pt_first, pt_last, pt_x, pt_y, mem_addr}, 0);
      check("t6_v1_consumed", exp_q.size(), 1);
      exp_q.delete();
      rst = 1'b0;
      repeat (4) step();
      check("t6_no_done", done_cnt - d0, 0);
      start_run(0, 2);
      wait_done(60);
      check("t6_rerun_done", done_cnt - d0, 1);

      // Randomized runs with random back-pressure
      rnd_ready = 1;
      for (int r = 0; r < 40; r++) begin
         int b;
         int c;
         if (r % 10 == 0) for (int i = 0; i < DEPTH; i++) ram[i] = DATA_W'($urandom);
         b = $urandom_range(0, DEPTH - 1);
         c = (r == 20) ? 600 : $urandom_range(0, 6);
         if (r % 7 == 3) b = DEPTH - 1;
         d0 = done_cnt;
         start_run(b, c);
         wait_done(10 * c + 50);
         check("rnd_done_once", done_cnt - d0, 1);
      end
      rnd_ready = 0;
      step();
      check("final_queue_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
